// File: rtl/multicycle_controller.sv
// Moore control FSM for a multi-cycle RV32I datapath with a shared memory,
// memory-ready stalls, a wait-cycle watchdog and a sticky trap state.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCSrc,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StTrap    = 4'd15
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       is_store_q, is_store_d;
    logic [1:0] cause_q, cause_d;
    logic       mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_q     <= 8'd0;
            is_store_q <= 1'b0;
            cause_q    <= CauseNone;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            is_store_q <= is_store_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = 8'd0;
        is_store_d = is_store_q;
        cause_d    = cause_q;
        mem_wait   = 1'b0;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;

        case (state_q)
            StFetch: begin
                mem_wait = 1'b1;
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b10;
                is_store_d = (Opcode == OpStore);
                case (Opcode)
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemAddr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = is_store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_wait = 1'b1;
                MemRead  = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                mem_wait = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = Zero;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
                trap = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Watchdog: a ready in the last permitted cycle still completes the handshake.
        if (mem_wait && !mem_ready) begin
            if (wait_q == WaitLast) begin
                state_d = StTrap;
                cause_d = CauseTimeout;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    assign trap_cause = cause_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver queues the expected output vector for each cycle,
// the monitor pops and compares it at the falling edge.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       mem_ready;
    logic       Zero;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic       PCSrc, retire, trap;
    logic [1:0] trap_cause;
    logic [3:0] state_o;

    multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, PCWrite IRWrite IorD MemRead MemWrite RegWrite MemtoReg,
    //  ALUSrcA ALUSrcB ALUOp, PCSrc retire trap, trap_cause}
    localparam logic [21:0] E_FETCH_W  = {4'd0,  7'b0001000, 6'b00_01_00, 3'b000, 2'b00};
    localparam logic [21:0] E_FETCH_R  = {4'd0,  7'b1101000, 6'b00_01_00, 3'b000, 2'b00};
    localparam logic [21:0] E_DECODE   = {4'd1,  7'b0000000, 6'b10_10_00, 3'b000, 2'b00};
    localparam logic [21:0] E_MEMADDR  = {4'd2,  7'b0000000, 6'b01_10_00, 3'b000, 2'b00};
    localparam logic [21:0] E_MEMRD    = {4'd3,  7'b0011000, 6'b00_00_00, 3'b000, 2'b00};
    localparam logic [21:0] E_MEMWB    = {4'd4,  7'b0000011, 6'b00_00_00, 3'b010, 2'b00};
    localparam logic [21:0] E_MEMWR_W  = {4'd5,  7'b0010100, 6'b00_00_00, 3'b000, 2'b00};
    localparam logic [21:0] E_MEMWR_R  = {4'd5,  7'b0010100, 6'b00_00_00, 3'b010, 2'b00};
    localparam logic [21:0] E_EXECR    = {4'd6,  7'b0000000, 6'b01_00_10, 3'b000, 2'b00};
    localparam logic [21:0] E_EXECI    = {4'd7,  7'b0000000, 6'b01_10_10, 3'b000, 2'b00};
    localparam logic [21:0] E_ALUWB    = {4'd8,  7'b0000010, 6'b00_00_00, 3'b010, 2'b00};
    localparam logic [21:0] E_BR_Z     = {4'd9,  7'b1000000, 6'b01_00_01, 3'b110, 2'b00};
    localparam logic [21:0] E_BR_NZ    = {4'd9,  7'b0000000, 6'b01_00_01, 3'b110, 2'b00};
    localparam logic [21:0] E_TRAP_ILL = {4'd15, 7'b0000000, 6'b00_00_00, 3'b001, 2'b01};
    localparam logic [21:0] E_TRAP_TO  = {4'd15, 7'b0000000, 6'b00_00_00, 3'b001, 2'b10};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [21:0] act;
    assign act = {state_o, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
                  ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire, trap, trap_cause};

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [21:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got %b, want %b", nm, $time, act, e);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; the expectation covers that cycle.
    task automatic cyc(input logic rst, input logic [6:0] op, input logic rdy, input logic z,
                       input logic [21:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n     = rst;
        Opcode    = op;
        mem_ready = rdy;
        Zero      = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n = 1'b0; Opcode = 7'd0; mem_ready = 1'b0; Zero = 1'b0;
        cyc(0, 7'd0, 0, 0, E_FETCH_W, "reset");

        // R-type: 0,1,6,8
        cyc(1, OP_R, 1, 0, E_FETCH_R, "r_fetch");
        cyc(1, OP_R, 0, 0, E_DECODE,  "r_decode");
        cyc(1, OP_R, 0, 0, E_EXECR,   "r_exec");
        cyc(1, OP_R, 0, 0, E_ALUWB,   "r_wb");
        // I-type
        cyc(1, OP_I, 1, 0, E_FETCH_R, "i_fetch");
        cyc(1, OP_I, 0, 0, E_DECODE,  "i_decode");
        cyc(1, OP_I, 0, 0, E_EXECI,   "i_exec");
        cyc(1, OP_I, 0, 0, E_ALUWB,   "i_wb");
        // LW with 3 wait cycles; last wait cycle has counter at limit but ready wins
        cyc(1, OP_LW, 1, 0, E_FETCH_R, "lw_fetch");
        cyc(1, OP_LW, 0, 0, E_DECODE,  "lw_decode");
        cyc(1, OP_BAD, 0, 0, E_MEMADDR, "lw_addr");
        cyc(1, OP_BAD, 0, 0, E_MEMRD,  "lw_rd_wait0");
        cyc(1, OP_BAD, 0, 0, E_MEMRD,  "lw_rd_wait1");
        cyc(1, OP_BAD, 0, 0, E_MEMRD,  "lw_rd_wait2");
        cyc(1, OP_BAD, 1, 0, E_MEMRD,  "lw_rd_ready");
        cyc(1, OP_BAD, 0, 0, E_MEMWB,  "lw_wb");
        // SW, opcode changed after DECODE must not redirect to MEM_RD
        cyc(1, OP_SW, 1, 0, E_FETCH_R, "sw_fetch");
        cyc(1, OP_SW, 0, 0, E_DECODE,  "sw_decode");
        cyc(1, OP_LW, 1, 0, E_MEMADDR, "sw_addr");
        cyc(1, OP_LW, 1, 0, E_MEMWR_R, "sw_wr");
        // BEQ taken / not taken
        cyc(1, OP_BEQ, 1, 0, E_FETCH_R, "beq1_fetch");
        cyc(1, OP_BEQ, 0, 0, E_DECODE,  "beq1_decode");
        cyc(1, OP_BEQ, 0, 1, E_BR_Z,    "beq1_branch");
        cyc(1, OP_BEQ, 1, 1, E_FETCH_R, "beq2_fetch");
        cyc(1, OP_BEQ, 0, 1, E_DECODE,  "beq2_decode");
        cyc(1, OP_BEQ, 0, 0, E_BR_NZ,   "beq2_branch");
        // FETCH stall, then SW whose 4th MEM_WR cycle gets ready just in time
        cyc(1, OP_SW, 0, 0, E_FETCH_W, "f_wait0");
        cyc(1, OP_SW, 0, 0, E_FETCH_W, "f_wait1");
        cyc(1, OP_SW, 1, 0, E_FETCH_R, "sw2_fetch");
        cyc(1, OP_SW, 0, 0, E_DECODE,  "sw2_decode");
        cyc(1, OP_SW, 0, 0, E_MEMADDR, "sw2_addr");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "sw2_wait0");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "sw2_wait1");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "sw2_wait2");
        cyc(1, OP_SW, 1, 0, E_MEMWR_R, "sw2_ready_at_limit");
        cyc(1, OP_R, 0, 0, E_FETCH_W,  "sw2_back_fetch");
        // Asynchronous reset in MEM_RD
        cyc(1, OP_LW, 1, 0, E_FETCH_R, "lw3_fetch");
        cyc(1, OP_LW, 0, 0, E_DECODE,  "lw3_decode");
        cyc(1, OP_LW, 0, 0, E_MEMADDR, "lw3_addr");
        cyc(1, OP_LW, 0, 0, E_MEMRD,   "lw3_rd_wait");
        cyc(0, OP_LW, 0, 0, E_FETCH_W, "async_reset");
        // Illegal opcode -> sticky trap
        cyc(1, OP_BAD, 1, 0, E_FETCH_R, "ill_fetch");
        cyc(1, OP_BAD, 0, 0, E_DECODE,  "ill_decode");
        cyc(1, OP_BAD, 1, 0, E_TRAP_ILL, "ill_trap0");
        cyc(1, OP_R,   0, 0, E_TRAP_ILL, "ill_trap1");
        cyc(1, OP_R,   1, 1, E_TRAP_ILL, "ill_trap2");
        cyc(0, OP_R,   0, 0, E_FETCH_W,  "ill_reset");
        // SW timeout: 4th MEM_WR cycle without ready
        cyc(1, OP_SW, 1, 0, E_FETCH_R, "to_fetch");
        cyc(1, OP_SW, 0, 0, E_DECODE,  "to_decode");
        cyc(1, OP_SW, 0, 0, E_MEMADDR, "to_addr");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "to_wait0");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "to_wait1");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "to_wait2");
        cyc(1, OP_SW, 0, 0, E_MEMWR_W, "to_wait3");
        cyc(1, OP_SW, 1, 0, E_TRAP_TO, "to_trap0");
        cyc(1, OP_SW, 0, 0, E_TRAP_TO, "to_trap1");
        cyc(0, OP_SW, 0, 0, E_FETCH_W, "to_reset");
        // FETCH timeout
        cyc(1, OP_R, 0, 0, E_FETCH_W, "fto_wait0");
        cyc(1, OP_R, 0, 0, E_FETCH_W, "fto_wait1");
        cyc(1, OP_R, 0, 0, E_FETCH_W, "fto_wait2");
        cyc(1, OP_R, 0, 0, E_FETCH_W, "fto_wait3");
        cyc(1, OP_R, 1, 0, E_TRAP_TO, "fto_trap");
        cyc(0, OP_R, 0, 0, E_FETCH_W, "fto_reset");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-memory, multi-cycle RV32I datapath: one ALU and one unified instruction/data memory, reused across cycles.
- Supports the same opcode set as the single-cycle decoder: R-type, I-type ALU, LW, SW and BEQ.
- Stalls on a memory ready handshake and traps on illegal opcodes or a memory timeout.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
- TIMEOUT_CYCLES, 16: maximum consecutive cycles waiting for mem_ready in any memory state before trapping; range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  7  IR[6:0]; sampled only in DECODE
- mem_ready  input  1  memory has completed the current read/write this cycle
- Zero  input  1  ALU zero flag; used only in BRANCH
- PCWrite  output  1  PC register load enable
- IRWrite  output  1  instruction register load enable
- IorD  output  1  0: memory address = PC; 1: memory address = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- RegWrite  output  1  register file write enable
- MemtoReg  output  1  0: write data = ALUOut; 1: write data = MDR
- ALUSrcA  output  2  00: PC; 01: register A; 10: OldPC
- ALUSrcB  output  2  00: register B; 01: constant 4; 10: immediate
- ALUOp  output  2  00: add; 01: subtract (branch compare); 10: decode funct fields
- PCSrc  output  1  0: PC input = ALU result; 1: PC input = ALUOut
- retire  output  1  one-cycle pulse in the final cycle of each completed instruction
- trap  output  1  sticky error flag
- trap_cause  output  2  00: none; 01: illegal opcode; 10: memory timeout
- state_o  output  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=15.
- Reset (asynchronous, rst_n=0):
  - state=FETCH, wait counter=0, trap=0, trap_cause=00.
  - All other outputs take their FETCH-state values with mem_ready=0.
- Default for every output not listed in a state: 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSrc=0.
  - IRWrite=PCWrite=mem_ready (combinational gating).
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target latched into ALUOut by the datapath).
  - Next state by Opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other value -> TRAP with trap_cause=01.
- MEM_ADDR:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00.
  - Next: LW -> MEM_RD; SW -> MEM_WR. The opcode is latched internally in DECODE; Opcode is not re-sampled.
- MEM_RD:
  - Outputs: MemRead=1, IorD=1.
  - mem_ready=1 -> MEM_WB; otherwise stay.
- MEM_WB:
  - Outputs: RegWrite=1, MemtoReg=1, retire=1.
  - Next: FETCH.
- MEM_WR:
  - Outputs: MemWrite=1, IorD=1.
  - retire=mem_ready.
  - mem_ready=1 -> FETCH; otherwise stay.
- EXEC_R:
  - Outputs: ALUSrcA=01, ALUSrcB=00, ALUOp=10.
  - Next: ALU_WB.
- EXEC_I:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=10.
  - Next: ALU_WB.
- ALU_WB:
  - Outputs: RegWrite=1, MemtoReg=0, retire=1.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero, retire=1.
  - Next: FETCH.
- TRAP:
  - All enables are 0; trap=1.
  - trap_cause holds its value.
  - Exit only via reset.
- Latency with mem_ready held at 1, in cycles: R-type 4, I-type 4, LW 5, SW 4, BEQ 3.
- Wait counter (8-bit):
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on any state change or when mem_ready=1.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ready=0 -> TRAP with trap_cause=10.
  - If mem_ready=1 in that same cycle, the handshake wins and no trap occurs.
- Memory requests never overlap: MemRead and MemWrite are never both 1.
- RegWrite is never 1 in any memory-wait state.
- Reset asserted mid-instruction: outputs go to FETCH values immediately, asynchronously, with no write pulse. Any in-flight memory handshake is abandoned.

Test Plan:
- Reset, then R-type 0110011 with mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8; retire pulses once on cycle 4.
- LW 0000011 with mem_ready low for 3 cycles in MEM_RD -> stays in state 3 for 4 cycles, MemRead=IorD=1 throughout; then MEM_WB with MemtoReg=1; total 8 cycles.
- BEQ 1100011 with Zero=1, then Zero=0 -> PCWrite=1 with PCSrc=1 in BRANCH; second run PCWrite=0; both complete in 3 cycles.
- Opcode 1111111 at DECODE -> TRAP, trap=1, trap_cause=01; mem_ready toggling leaves all outputs 0 until rst_n=0.
- TIMEOUT_CYCLES=4, SW with mem_ready=0 -> TRAP on the 4th MEM_WR cycle, trap_cause=10. Repeat with mem_ready=1 on that exact cycle -> FETCH, no trap.
- rst_n pulsed low during MEM_RD -> state_o=0 asynchronously; MemRead reflects FETCH (1); trap cleared.
